// File: rtl/bank_rsp_queue_pkg.sv
// Shared definitions for the bank core-response queue: the response-entry layout
// and occupancy/entry width helpers used by the top level and the queue controller.
package bank_rsp_queue_pkg;

   localparam int DEF_NUM_PORTS = 1;
   localparam int DEF_WORD_SIZE = 4;
   localparam int DEF_TAG_WIDTH = 8;

   // Entry layout for the default bank configuration.
   // The top level declares the same {tag, pmask, data} shape from its own parameters.
   typedef struct packed {
      logic [DEF_TAG_WIDTH-1:0]                 tag;
      logic [DEF_NUM_PORTS-1:0]                 pmask;
      logic [DEF_NUM_PORTS*DEF_WORD_SIZE*8-1:0] data;
   } rsp_entry_t;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int entry_width(input int tag_w, input int num_ports, input int word_size);
      return tag_w + num_ports + num_ports * word_size * 8;
   endfunction

endpackage

// File: rtl/rsp_queue_ctrl.sv
// Pointer, occupancy and flag control for the bank response queue.
// Flags derive from the registered count only, so the pipeline sees no combinational loop.
module rsp_queue_ctrl
   import bank_rsp_queue_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int ALM_FULL_MARGIN = 2,
   parameter int PTR_W           = $clog2(DEPTH),
   parameter int CNT_W           = occ_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push_req,
   input  logic             i_rsp_ready,
   output logic [PTR_W-1:0] o_wr_ptr,
   output logic [PTR_W-1:0] o_rd_ptr,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_alm_full,
   output logic             o_overflow,
   output logic             o_rsp_valid,
   output logic             o_push_ok,
   output logic             o_pop
);

   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ALM_LVL  = CNT_W'(DEPTH - ALM_FULL_MARGIN);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic             w_full;
   logic             w_valid;
   logic             w_pop;
   logic             w_push_ok;

   assign w_full    = (r_count == FULL_LVL);
   assign w_valid   = (r_count != '0);
   assign w_pop     = w_valid & i_rsp_ready;
   // A pop in the same cycle frees the slot, so a full queue still accepts the push.
   assign w_push_ok = i_push_req & (~w_full | w_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (i_push_req & w_full & ~w_pop) r_overflow <= 1'b1;
      end
   end

   assign o_wr_ptr    = r_wr_ptr;
   assign o_rd_ptr    = r_rd_ptr;
   assign o_count     = r_count;
   assign o_full      = w_full;
   assign o_alm_full  = (r_count >= ALM_LVL);
   assign o_overflow  = r_overflow;
   assign o_rsp_valid = w_valid;
   assign o_push_ok   = w_push_ok;
   assign o_pop       = w_pop;

endmodule

// File: rtl/bank_rsp_queue.sv
// Per-bank core-response buffer: captures completed reads in order and presents them
// to the core-response arbiter, with an almost-full credit covering data-store latency.
module bank_rsp_queue
   import bank_rsp_queue_pkg::*;
#(
   parameter int NUM_PORTS       = 1,
   parameter int WORD_SIZE       = 4,
   parameter int TAG_WIDTH       = 8,
   parameter int DEPTH           = 4,
   parameter int ALM_FULL_MARGIN = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             push_valid,
   input  logic [TAG_WIDTH-1:0]             push_tag,
   input  logic [NUM_PORTS-1:0]             push_pmask,
   input  logic [NUM_PORTS*WORD_SIZE*8-1:0] push_data,
   output logic                             alm_full,
   output logic                             full,
   output logic                             rsp_valid,
   output logic [TAG_WIDTH-1:0]             rsp_tag,
   output logic [NUM_PORTS-1:0]             rsp_pmask,
   output logic [NUM_PORTS*WORD_SIZE*8-1:0] rsp_data,
   input  logic                             rsp_ready,
   output logic [occ_width(DEPTH)-1:0]      count,
   output logic                             overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = occ_width(DEPTH);
   localparam int DW    = NUM_PORTS * WORD_SIZE * 8;

   typedef struct packed {
      logic [TAG_WIDTH-1:0] tag;
      logic [NUM_PORTS-1:0] pmask;
      logic [DW-1:0]        data;
   } entry_t;

   logic [PTR_W-1:0] w_wr_ptr;
   logic [PTR_W-1:0] w_rd_ptr;
   logic [CNT_W-1:0] w_count;
   logic             w_rsp_valid;
   logic             w_push_ok;
   logic             w_pop;
   logic             w_push_req;
   entry_t           w_head;
   entry_t           r_mem [DEPTH];

   // Responses with no active port carry nothing for the core and never occupy a slot.
   assign w_push_req = push_valid & (push_pmask != '0);

   rsp_queue_ctrl #(
      .DEPTH           (DEPTH),
      .ALM_FULL_MARGIN (ALM_FULL_MARGIN),
      .PTR_W           (PTR_W),
      .CNT_W           (CNT_W)
   ) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .i_push_req  (w_push_req),
      .i_rsp_ready (rsp_ready),
      .o_wr_ptr    (w_wr_ptr),
      .o_rd_ptr    (w_rd_ptr),
      .o_count     (w_count),
      .o_full      (full),
      .o_alm_full  (alm_full),
      .o_overflow  (overflow),
      .o_rsp_valid (w_rsp_valid),
      .o_push_ok   (w_push_ok),
      .o_pop       (w_pop)
   );

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[w_wr_ptr] <= '{tag: push_tag, pmask: push_pmask, data: push_data};
   end

   assign w_head = r_mem[w_rd_ptr];

   // Head fields are zeroed when empty so stale storage never leaks to the arbiter.
   assign rsp_valid = w_rsp_valid;
   assign rsp_tag   = w_rsp_valid ? w_head.tag   : '0;
   assign rsp_pmask = w_rsp_valid ? w_head.pmask : '0;
   assign rsp_data  = w_rsp_valid ? w_head.data  : '0;
   assign count     = w_count;

endmodule

// File: tb/tb_bank_rsp_queue.sv
// Bench for bank_rsp_queue: directed scenarios plus random traffic checked against
// a queue-based reference model of the response buffer.
module tb_bank_rsp_queue;

   localparam int DEPTH  = 4;
   localparam int MARGIN = 2;
   localparam int EW     = 8 + 1 + 32;

   logic        clk;
   logic        reset;
   logic        push_valid;
   logic [7:0]  push_tag;
   logic [0:0]  push_pmask;
   logic [31:0] push_data;
   logic        alm_full;
   logic        full;
   logic        rsp_valid;
   logic [7:0]  rsp_tag;
   logic [0:0]  rsp_pmask;
   logic [31:0] rsp_data;
   logic        rsp_ready;
   logic [2:0]  count;
   logic        overflow;

   logic [EW-1:0] exp_q[$];
   logic          m_overflow;
   int            n_total;
   int            n_pass;
   int            n_fail;

   bank_rsp_queue #(
      .NUM_PORTS       (1),
      .WORD_SIZE       (4),
      .TAG_WIDTH       (8),
      .DEPTH           (DEPTH),
      .ALM_FULL_MARGIN (MARGIN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .push_valid (push_valid),
      .push_tag   (push_tag),
      .push_pmask (push_pmask),
      .push_data  (push_data),
      .alm_full   (alm_full),
      .full       (full),
      .rsp_valid  (rsp_valid),
      .rsp_tag    (rsp_tag),
      .rsp_pmask  (rsp_pmask),
      .rsp_data   (rsp_data),
      .rsp_ready  (rsp_ready),
      .count      (count),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model: head of queue, occupancy and flags.
   task automatic check_all(input string tag);
      int            sz;
      logic [EW-1:0] head;
      sz   = exp_q.size();
      head = (sz != 0) ? exp_q[0] : '0;
      chk({tag, ".count"},     64'(count),     64'(sz));
      chk({tag, ".valid"},     64'(rsp_valid), 64'(sz != 0));
      chk({tag, ".full"},      64'(full),      64'(sz == DEPTH));
      chk({tag, ".alm_full"},  64'(alm_full),  64'(sz >= DEPTH - MARGIN));
      chk({tag, ".overflow"},  64'(overflow),  64'(m_overflow));
      chk({tag, ".tag"},       64'(rsp_tag),   64'(head[40:33]));
      chk({tag, ".pmask"},     64'(rsp_pmask), 64'(head[32]));
      chk({tag, ".data"},      64'(rsp_data),  64'(head[31:0]));
   endtask

   // Drive one cycle of stimulus, advance the model by the queue's rules, then check.
   task automatic do_cycle(input string tag, input logic pv, input logic [7:0] tg,
                           input logic pm, input logic [31:0] dt, input logic rdy);
      logic m_pop;
      logic m_push;
      push_valid = pv;
      push_tag   = tg;
      push_pmask = pm;
      push_data  = dt;
      rsp_ready  = rdy;
      m_pop  = (exp_q.size() != 0) && rdy;
      m_push = pv && (pm != 1'b0) && ((exp_q.size() < DEPTH) || m_pop);
      if (pv && (pm != 1'b0) && !m_push) m_overflow = 1'b1;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({tg, pm, dt});
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic apply_reset();
      reset      = 1'b1;
      push_valid = 1'b0;
      rsp_ready  = 1'b0;
      exp_q.delete();
      m_overflow = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      n_total    = 0;
      n_pass     = 0;
      n_fail     = 0;
      m_overflow = 1'b0;
      reset      = 1'b1;
      push_valid = 1'b0;
      push_tag   = '0;
      push_pmask = '0;
      push_data  = '0;
      rsp_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_all("por");

      // Reset mid-traffic with three entries held.
      for (int i = 0; i < 3; i++) do_cycle("rst_fill", 1'b1, 8'(i + 16), 1'b1, $urandom, 1'b0);
      chk("rst_pre_count", 64'(count), 64'd3);
      push_valid = 1'b1;
      push_pmask = 1'b1;
      rsp_ready  = 1'b1;
      reset      = 1'b1;
      #2;
      chk("rst_async_count", 64'(count), 64'd0);
      @(posedge clk);
      #1;
      exp_q.delete();
      m_overflow = 1'b0;
      chk("rst_count",    64'(count),     64'd0);
      chk("rst_valid",    64'(rsp_valid), 64'd0);
      chk("rst_data",     64'(rsp_data),  64'd0);
      chk("rst_overflow", 64'(overflow),  64'd0);
      chk("rst_alm_full", 64'(alm_full),  64'd0);
      reset      = 1'b0;
      push_valid = 1'b0;
      rsp_ready  = 1'b0;

      // Single push held stable, then popped.
      do_cycle("single_push", 1'b1, 8'h2A, 1'b1, 32'hDEADBEEF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("single_hold_tag",  64'(rsp_tag),  64'h2A);
         chk("single_hold_data", 64'(rsp_data), 64'hDEADBEEF);
         do_cycle("single_hold", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
      end
      do_cycle("single_pop", 1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
      chk("single_after_pop_valid", 64'(rsp_valid), 64'd0);

      // Fill, drop on full, drain in order.
      for (int i = 1; i <= 4; i++) begin
         do_cycle("fill", 1'b1, 8'(i), 1'b1, 32'(i * 32'h1111), 1'b0);
         if (i == 1) chk("fill1_alm_full", 64'(alm_full), 64'd0);
         if (i == 2) chk("fill2_alm_full", 64'(alm_full), 64'd1);
         if (i == 3) chk("fill3_full",     64'(full),     64'd0);
         if (i == 4) chk("fill4_full",     64'(full),     64'd1);
      end
      do_cycle("drop", 1'b1, 8'd5, 1'b1, 32'h5555, 1'b0);
      chk("drop_overflow", 64'(overflow), 64'd1);
      chk("drop_count",    64'(count),    64'd4);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_order", 64'(rsp_tag), 64'(i));
         do_cycle("drain", 1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
      end
      chk("drain_overflow_sticky", 64'(overflow), 64'd1);

      // Full with simultaneous push and pop.
      apply_reset();
      check_all("rst2");
      for (int i = 1; i <= 4; i++) do_cycle("fill2", 1'b1, 8'(i), 1'b1, $urandom, 1'b0);
      do_cycle("full_push_pop", 1'b1, 8'd9, 1'b1, 32'h9999_9999, 1'b1);
      chk("fpp_count",    64'(count),    64'd4);
      chk("fpp_overflow", 64'(overflow), 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk("fpp_order", 64'(rsp_tag), 64'((i < 3) ? (i + 2) : 9));
         do_cycle("fpp_drain", 1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
      end

      // Zero pmask is ignored.
      do_cycle("zero_pmask", 1'b1, 8'h77, 1'b0, 32'h1234, 1'b0);
      chk("zero_pmask_count", 64'(count),     64'd0);
      chk("zero_pmask_valid", 64'(rsp_valid), 64'd0);

      // Streaming with wrap-around.
      for (int i = 0; i < 20; i++) begin
         if (i > 0) chk("stream_order", 64'(rsp_tag), 64'(8'h40 + i - 1));
         do_cycle("stream", 1'b1, 8'(8'h40 + i), 1'b1, $urandom, 1'b1);
         chk("stream_cnt_le1", 64'(count <= 3'd1), 64'd1);
      end
      do_cycle("stream_tail", 1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
      chk("stream_empty", 64'(rsp_valid), 64'd0);

      // Random traffic against the model.
      apply_reset();
      for (int i = 0; i < 300; i++) begin
         do_cycle("rand", ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 4) != 0),
                  $urandom, ($urandom_range(0, 2) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
